// File: rtl/ov7670_cfg_pkg.sv
// Shared constants, FSM state type and the fixed OV7670 register table
// streamed by ov7670_sccb_config.
package ov7670_cfg_pkg;

  localparam logic [7:0] SCCB_ID   = 8'h42;
  localparam logic [7:0] CFG_END   = 8'hFF;
  localparam logic [7:0] CFG_DELAY = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_BIT, ST_STOP, ST_GAP, ST_DELAY, ST_DONE
  } state_e;

  // Entry = {addr, data}; the table must hit CFG_END before index 31.
  function automatic logic [15:0] cfg_entry(input logic [4:0] idx);
    logic [15:0] e;
    case (idx)
      5'd0:    e = 16'h1280;
      5'd1:    e = 16'hF000;
      5'd2:    e = 16'h1214;
      5'd3:    e = 16'h40D0;
      5'd4:    e = 16'h1101;
      5'd5:    e = 16'h3A04;
      default: e = 16'hFFFF;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sccb_qtick.sv
// SCL quarter-period divider: pulses qtick once every QTR_DIV enabled cycles
// while run is high; clr restarts the count.
module sccb_qtick #(
  parameter int QTR_DIV = 62
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  input  logic run,
  output logic qtick
);
  localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // qtick must not depend on clr: clr is derived from the FSM's next state.
  assign qtick = ena && run && (cnt_q == CW'(QTR_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      if (clr || qtick) cnt_d = '0;
      else if (run)     cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// Streams the OV7670 configuration table over SCCB (3-phase writes) after
// start or, with AUTO_START, straight out of reset.
//
// state    | meaning
// IDLE     | after reset, waiting for start (or auto start)
// LOAD     | fetch table entry idx, decode end/delay markers
// START    | 2 quarters: SDA falls while SCL high
// BIT      | 27 slots x 4 quarters, ACK slots at 8/17/26
// STOP     | 3 quarters: SDA rises while SCL high
// GAP      | GAP_QTRS idle quarters between writes
// DELAY    | DELAY_CYC idle cycles
// DONE     | table finished, waiting for start
module ov7670_sccb_config
  import ov7670_cfg_pkg::*;
#(
  parameter int QTR_DIV    = 62,
  parameter int GAP_QTRS   = 8,
  parameter int DELAY_CYC  = 250000,
  parameter int AUTO_START = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       sio_d_in,
  output logic       sio_c,
  output logic       sio_d_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [4:0] idx
);
  localparam int QW = (GAP_QTRS > 4) ? $clog2(GAP_QTRS) : 2;
  localparam int DW = (DELAY_CYC > 2) ? $clog2(DELAY_CYC) : 1;

  state_e        state_q, state_d;
  logic [QW-1:0] qtr_q, qtr_d;
  logic [4:0]    bit_q, bit_d;
  logic [26:0]   shreg_q, shreg_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [4:0]    idx_q, idx_d;
  logic          busy_q, busy_d, done_q, done_d, nack_q, nack_d;
  logic          sio_c_q, sio_c_d, sio_d_oe_q, sio_d_oe_d;
  logic [15:0]   entry;
  logic          qtick, q_run, q_clr, ack_q, ack_d;

  assign q_run = state_q inside {ST_START, ST_BIT, ST_STOP, ST_GAP};
  assign q_clr = (state_d != state_q) && (state_d inside {ST_START, ST_BIT, ST_STOP, ST_GAP});
  assign ack_q = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
  assign ack_d = (bit_d == 5'd8) || (bit_d == 5'd17) || (bit_d == 5'd26);

  sccb_qtick #(.QTR_DIV(QTR_DIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (q_clr),
    .run   (q_run),
    .qtick (qtick)
  );

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    nack_d  = nack_q;
    entry   = cfg_entry(idx_q);
    if (ena) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start || (state_q == ST_IDLE && AUTO_START != 0)) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            done_d  = 1'b0;
            nack_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        ST_LOAD: begin
          qtr_d = '0;
          bit_d = '0;
          if (entry[15:8] == CFG_END) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (entry[15:8] == CFG_DELAY) begin
            state_d = ST_DELAY;
            dly_d   = DW'(DELAY_CYC - 1);
          end else begin
            state_d = ST_START;
            // ACK slots hold 1 so the bus is released there.
            shreg_d = {SCCB_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
          end
        end
        ST_START: if (qtick) begin
          if (qtr_q == QW'(1)) begin
            state_d = ST_BIT;
            qtr_d   = '0;
          end else qtr_d = qtr_q + 1'b1;
        end
        ST_BIT: if (qtick) begin
          if (qtr_q == QW'(2) && ack_q && sio_d_in) nack_d = 1'b1;
          if (qtr_q == QW'(3)) begin
            qtr_d = '0;
            if (bit_q == 5'd26) state_d = ST_STOP;
            else begin
              bit_d   = bit_q + 5'd1;
              shreg_d = {shreg_q[25:0], 1'b0};
            end
          end else qtr_d = qtr_q + 1'b1;
        end
        ST_STOP: if (qtick) begin
          if (qtr_q == QW'(2)) begin
            state_d = ST_GAP;
            qtr_d   = '0;
          end else qtr_d = qtr_q + 1'b1;
        end
        ST_GAP: if (qtick) begin
          if (qtr_q == QW'(GAP_QTRS - 1)) begin
            state_d = ST_LOAD;
            idx_d   = idx_q + 5'd1;
          end else qtr_d = qtr_q + 1'b1;
        end
        ST_DELAY: begin
          if (dly_q == '0) begin
            state_d = ST_LOAD;
            idx_d   = idx_q + 5'd1;
          end else dly_d = dly_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Bus levels follow the next state so the pins are registered, glitch-free.
    sio_c_d    = 1'b1;
    sio_d_oe_d = 1'b0;
    case (state_d)
      ST_START: sio_d_oe_d = (qtr_d == QW'(1));
      ST_BIT: begin
        sio_c_d    = qtr_d[1];
        sio_d_oe_d = ack_d ? 1'b0 : ~shreg_d[26];
      end
      ST_STOP: begin
        sio_c_d    = (qtr_d != '0);
        sio_d_oe_d = (qtr_d != QW'(2));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      qtr_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      dly_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      sio_c_q    <= 1'b1;
      sio_d_oe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      dly_q      <= dly_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      sio_c_q    <= sio_c_d;
      sio_d_oe_q <= sio_d_oe_d;
    end
  end

  assign sio_c    = sio_c_q;
  assign sio_d_oe = sio_d_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nack     = nack_q;
  assign idx      = idx_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: SCCB slave model decodes writes into a
// scoreboard; scenario table drives NACK injection, ena stalls and restarts.
module tb_ov7670_sccb_config;

  typedef struct {
    int nack_wr;    // 1-based write that gets a NACK (0 = none)
    int nack_slot;  // ACK slot index 0..2 within that write
    int stall_bit;  // bit of write 1 where ena drops (-1 = none)
    int bstart_wr;  // write during which start is pulsed while busy (0 = none)
    bit exp_nack;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0;
  logic sio_c, sio_d_oe, busy, done, nack;
  logic [4:0] idx;
  logic a_sio_c, a_sio_d_oe, a_busy, a_done, a_nack;
  logic [4:0] a_idx;
  logic slave_low = 1'b0;
  wire  sda = ~(sio_d_oe | slave_low);

  int n_pass = 0, n_tot = 0;
  logic [23:0] exp_q[$];
  logic [15:0] exp_writes [5] = '{16'h1280, 16'h1214, 16'h40D0, 16'h1101, 16'h3A04};
  int          exp_idx    [5] = '{0, 2, 3, 4, 5};

  always #5 clk = ~clk;

  ov7670_sccb_config #(.QTR_DIV(2), .GAP_QTRS(8), .DELAY_CYC(40), .AUTO_START(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sio_d_in(sda),
    .sio_c(sio_c), .sio_d_oe(sio_d_oe), .busy(busy), .done(done), .nack(nack), .idx(idx)
  );

  ov7670_sccb_config #(.QTR_DIV(2), .GAP_QTRS(8), .DELAY_CYC(40), .AUTO_START(1)) dut_auto (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .start(1'b0), .sio_d_in(~a_sio_d_oe),
    .sio_c(a_sio_c), .sio_d_oe(a_sio_d_oe), .busy(a_busy), .done(a_done), .nack(a_nack), .idx(a_idx)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // SCCB slave: decodes START/bits/STOP on the negative clock edge.
  logic prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0, inj_chk = 1'b0;
  logic gap_watch = 1'b0, gap_bad = 1'b0;
  int bitcnt = 0, byte_cnt = 0, wr_no = 0, nack_wr = 0, nack_slot = 0;
  int cyc = 0, stop1_cyc = -1, start2_cyc = -1;
  logic [7:0]  sh = '0;
  logic [23:0] frame = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 1'b0; slave_low = 1'b0; bitcnt = 0; inj_chk = 1'b0; gap_watch = 1'b0;
    end else begin
      if (start && !busy) begin
        wr_no = 0; gap_watch = 1'b0; gap_bad = 1'b0; stop1_cyc = -1; start2_cyc = -1;
      end
      if (sio_c && prev_scl && prev_sda && !sda) begin
        in_frame = 1'b1; bitcnt = 0; byte_cnt = 0; frame = '0; wr_no++;
        if (wr_no == 2 && gap_watch) begin start2_cyc = cyc; gap_watch = 1'b0; end
      end else if (sio_c && prev_scl && !prev_sda && sda && in_frame) begin
        in_frame = 1'b0;
        if (byte_cnt == 3) begin
          if (exp_q.size() == 0) begin
            n_tot++;
            $display("FAIL sb_extra_write: got %h expected none", frame);
          end else check("sb_write", {8'h0, frame}, {8'h0, exp_q.pop_front()});
        end
        if (wr_no == 1) begin stop1_cyc = cyc; gap_watch = 1'b1; end
      end else if (in_frame && sio_c && !prev_scl) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], sda}; bitcnt++;
        end else begin
          if (wr_no == nack_wr && byte_cnt == nack_slot) begin
            check("nack_before_slot", nack, 0); inj_chk = 1'b1;
          end
          frame = {frame[15:0], sh}; byte_cnt++; bitcnt = 0;
        end
      end else if (in_frame && !sio_c && prev_scl) begin
        if (inj_chk) begin check("nack_at_slot", nack, 1); inj_chk = 1'b0; end
        slave_low = (bitcnt == 8) && !(wr_no == nack_wr && byte_cnt == nack_slot);
      end
      if (gap_watch && !(sio_c && !sio_d_oe)) gap_bad = 1'b1;
    end
    prev_scl = sio_c;
    prev_sda = ~(sio_d_oe | slave_low);
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int t1, t2, t3;
    logic cap_c, cap_oe, ok;
    nack_wr = v.nack_wr; nack_slot = v.nack_slot;
    for (int i = 0; i < 5; i++) exp_q.push_back({8'h42, exp_writes[i]});
    pulse_start();
    @(posedge clk); #1;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_nack_clr", nack, 0);
    check("start_idx", idx, 0);
    fork
      begin
        if (v.stall_bit >= 0) begin
          t1 = 0;
          while (!(wr_no == 1 && in_frame && bitcnt == v.stall_bit && !sio_c) && t1 < 2000) begin
            @(posedge clk); #1; t1++;
          end
          check("stall_reached", t1 < 2000, 1);
          cap_c = sio_c; cap_oe = sio_d_oe; ok = 1'b1; ena = 1'b0;
          repeat (17) begin
            @(posedge clk); #1;
            if (sio_c !== cap_c || sio_d_oe !== cap_oe) ok = 1'b0;
          end
          ena = 1'b1;
          check("stall_hold", ok, 1);
        end
      end
      begin
        if (v.bstart_wr > 0) begin
          t2 = 0;
          while (!(wr_no == v.bstart_wr && in_frame) && t2 < 4000) begin
            @(posedge clk); #1; t2++;
          end
          check("bstart_reached", t2 < 4000, 1);
          pulse_start();
          @(posedge clk); #1;
          check("bstart_idx", idx, exp_idx[v.bstart_wr-1]);
          check("bstart_busy", busy, 1);
        end
      end
    join
    t3 = 0;
    while (!done && t3 < 5000) begin @(posedge clk); #1; t3++; end
    check("done_timeout", t3 < 5000, 1);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_nack", nack, v.exp_nack);
    check("end_idx", idx, 6);
    check("sb_all_writes", exp_q.size(), 0);
    check("delay_gap_len", (start2_cyc - stop1_cyc) >= 56, 1);
    check("delay_bus_idle", gap_bad, 0);
  endtask

  vec_t vecs [4];

  initial begin
    int t;
    vecs[0] = '{nack_wr: 0, nack_slot: 0, stall_bit: -1, bstart_wr: 0, exp_nack: 1'b0};
    vecs[1] = '{nack_wr: 3, nack_slot: 1, stall_bit: -1, bstart_wr: 0, exp_nack: 1'b1};
    vecs[2] = '{nack_wr: 0, nack_slot: 0, stall_bit: 5,  bstart_wr: 3, exp_nack: 1'b0};
    vecs[3] = '{nack_wr: 5, nack_slot: 2, stall_bit: -1, bstart_wr: 0, exp_nack: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_sio_c", sio_c, 1);
    check("rst_sio_d_oe", sio_d_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_idx", idx, 0);
    check("rst_auto_busy", a_busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("auto_start_busy", a_busy, 1);
    repeat (5) @(posedge clk);
    #1;
    check("no_auto_idle", busy, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset in the middle of write 4.
    nack_wr = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back({8'h42, exp_writes[i]});
    pulse_start();
    t = 0;
    while (!(wr_no == 4 && in_frame && bitcnt >= 2) && t < 4000) begin @(posedge clk); #1; t++; end
    check("rst_mid_reached", t < 4000, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_mid_sio_c", sio_c, 1);
    check("rst_mid_sio_d_oe", sio_d_oe, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_idx", idx, 0);
    check("rst_mid_auto_busy", a_busy, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("auto_restart_busy", a_busy, 1);
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_auto_idle", busy, 0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule
